// File: rtl/mem_arbiter_if.sv
// Cache-side request/response signals and the backing-memory port of the ICache/DCache memory arbiter.
// The slave view belongs to the arbiter; the master view belongs to the caches and the memory model.
interface mem_arbiter_if #(
  parameter int LINE_BITS = 128
);
  logic                 ic_req;
  logic [31:0]          ic_addr;
  logic                 ic_ready;
  logic [LINE_BITS-1:0] ic_data;

  logic                 dc_req;
  logic                 dc_we;
  logic [31:0]          dc_addr;
  logic [LINE_BITS-1:0] dc_wdata;
  logic                 dc_ready;
  logic [LINE_BITS-1:0] dc_rdata;

  logic                 mem_req;
  logic                 mem_we;
  logic [31:0]          mem_addr;
  logic [LINE_BITS-1:0] mem_wdata;
  logic [LINE_BITS-1:0] mem_rdata;

  logic                 busy;

  modport slave (
    input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata,
    output ic_ready, ic_data, dc_ready, dc_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata,
    input  ic_ready, ic_data, dc_ready, dc_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates ICache fills and DCache fills/writebacks onto one backing memory, one transfer at a time.
// A grant is followed by LATENCY access cycles and then a single-cycle ready pulse to the owner.
module mem_arbiter #(
  parameter int LATENCY   = 5,
  parameter int LINE_BITS = 128
) (
  input  logic          clock,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       lastGrantDc;
  logic       ownerDc;
  logic       ownerWe;
  logic       pickDc;

  // On a tie, the requester that was not served last wins.
  assign pickDc = bus.dc_req && (!bus.ic_req || !lastGrantDc);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      lastGrantDc   <= 1'b0;
      ownerDc       <= 1'b0;
      ownerWe       <= 1'b0;
      bus.ic_ready  <= 1'b0;
      bus.ic_data   <= '0;
      bus.dc_ready  <= 1'b0;
      bus.dc_rdata  <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ic_req || bus.dc_req) begin
            ownerDc       <= pickDc;
            ownerWe       <= pickDc && bus.dc_we;
            lastGrantDc   <= pickDc;
            cnt           <= CNT_LOAD;
            bus.mem_req   <= 1'b1;
            bus.mem_addr  <= pickDc ? bus.dc_addr : bus.ic_addr;
            bus.mem_wdata <= pickDc ? bus.dc_wdata : '0;
            // With a one-cycle access the write strobe must go out straight away.
            bus.mem_we    <= pickDc && bus.dc_we && (LATENCY == 1);
            bus.busy      <= 1'b1;
            state         <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            if (!ownerWe) begin
              if (ownerDc) bus.dc_rdata <= bus.mem_rdata;
              else         bus.ic_data  <= bus.mem_rdata;
            end
            bus.ic_ready  <= !ownerDc;
            bus.dc_ready  <= ownerDc;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            state         <= RESPOND;
          end else begin
            cnt        <= cnt - 4'd1;
            // Strobe lands in the final access cycle, when the counter reads zero.
            bus.mem_we <= ownerWe && (cnt == 4'd1);
          end
        end
        RESPOND: begin
          bus.ic_ready <= 1'b0;
          bus.dc_ready <= 1'b0;
          bus.busy     <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: a transaction-level model predicts grants, timing and data.
module tb_mem_arbiter;
  localparam int LAT = 5;
  localparam int LB  = 128;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mem_arbiter_if #(.LINE_BITS(LB)) bus  ();
  mem_arbiter_if #(.LINE_BITS(LB)) bus1 ();

  assign bus.mem_rdata  = {4{bus.mem_addr}};
  assign bus1.mem_rdata = {4{bus1.mem_addr}};

  mem_arbiter #(.LATENCY(LAT), .LINE_BITS(LB)) dut  (.clock(clock), .reset(reset), .bus(bus));
  mem_arbiter #(.LATENCY(1),   .LINE_BITS(LB)) dut1 (.clock(clock), .reset(reset), .bus(bus1));

  typedef struct {
    int          cyc;
    bit          isDc;
    logic [LB-1:0] ic;
    logic [LB-1:0] dc;
  } resp_t;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [LB-1:0] wdata;
  } wr_t;

  resp_t expQ[$];
  wr_t   wrQ[$];

  int checks = 0;
  int errors = 0;
  int edgeN = 0;
  int lastEdge = -1;
  int freeAt = 0;
  int curStart = -100;
  logic [31:0]   curAddr = '0;
  bit            mLastDc = 1'b0;
  logic [LB-1:0] mIc = '0;
  logic [LB-1:0] mDc = '0;

  int icDone = 0;
  int dcDone = 0;
  int pct = 0;

  task automatic chk(string name, logic [LB-1:0] act, logic [LB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one transfer at a time, granted at an edge when the arbiter is free.
  always @(posedge clock) begin
    bit          pickDc;
    logic [31:0] a;
    resp_t       r;
    wr_t         w;
    if (reset) begin
      expQ.delete();
      wrQ.delete();
      mLastDc  = 1'b0;
      mIc      = '0;
      mDc      = '0;
      freeAt   = 0;
      curStart = -100;
      curAddr  = '0;
    end else if (edgeN >= freeAt && (bus.ic_req || bus.dc_req)) begin
      pickDc   = bus.dc_req && (!bus.ic_req || !mLastDc);
      mLastDc  = pickDc;
      a        = pickDc ? bus.dc_addr : bus.ic_addr;
      curStart = edgeN;
      curAddr  = a;
      freeAt   = edgeN + LAT + 2;
      if (pickDc && bus.dc_we) begin
        w.cyc   = edgeN + LAT - 1;
        w.addr  = a;
        w.wdata = bus.dc_wdata;
        wrQ.push_back(w);
      end else if (pickDc) begin
        mDc = {4{a}};
      end else begin
        mIc = {4{a}};
      end
      r.cyc  = edgeN + LAT;
      r.isDc = pickDc;
      r.ic   = mIc;
      r.dc   = mDc;
      expQ.push_back(r);
    end
    lastEdge = edgeN;
    edgeN++;
  end

  // Monitor: compares DUT outputs against the model every cycle, away from the active edge.
  always @(negedge clock) begin
    bit    accs;
    bit    bsy;
    resp_t r;
    wr_t   w;
    if (!reset) begin
      accs = (lastEdge >= curStart) && (lastEdge < curStart + LAT);
      bsy  = (lastEdge >= curStart) && (lastEdge <= curStart + LAT);
      chk("busy", LB'(bus.busy), LB'(bsy));
      chk("mem_req", LB'(bus.mem_req), LB'(accs));
      chk("mem_addr", LB'(bus.mem_addr), LB'(accs ? curAddr : 32'h0));
      if (!accs) chk("mem_wdata_idle", bus.mem_wdata, '0);

      if (bus.mem_we) begin
        if (wrQ.size() == 0) begin
          chk("mem_we_unexpected", LB'(bus.mem_we), '0);
        end else begin
          w = wrQ.pop_front();
          chk("mem_we_cycle", LB'(lastEdge), LB'(w.cyc));
          chk("mem_we_addr", LB'(bus.mem_addr), LB'(w.addr));
          chk("mem_we_wdata", bus.mem_wdata, w.wdata);
        end
      end else if (wrQ.size() != 0 && wrQ[0].cyc <= lastEdge) begin
        w = wrQ.pop_front();
        chk("mem_we_missing", LB'(bus.mem_we), LB'(1));
      end

      if (bus.ic_ready && bus.dc_ready) chk("both_ready", LB'(bus.dc_ready), '0);
      if (bus.ic_ready || bus.dc_ready) begin
        if (expQ.size() == 0) begin
          chk("ready_unexpected", LB'({bus.ic_ready, bus.dc_ready}), '0);
        end else begin
          r = expQ.pop_front();
          chk("ready_owner_dc", LB'(bus.dc_ready), LB'(r.isDc));
          chk("ready_cycle", LB'(lastEdge), LB'(r.cyc));
          chk("ic_data", bus.ic_data, r.ic);
          chk("dc_rdata", bus.dc_rdata, r.dc);
        end
      end else if (expQ.size() != 0 && expQ[0].cyc <= lastEdge) begin
        r = expQ.pop_front();
        chk(r.isDc ? "dc_ready_missing" : "ic_ready_missing", '0, LB'(1));
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    if (bus.ic_ready) begin
      bus.ic_req = 1'b0;
      icDone++;
    end
    if (bus.dc_ready) begin
      bus.dc_req = 1'b0;
      bus.dc_we  = 1'b0;
      dcDone++;
    end
    if (!bus.ic_req && int'($urandom_range(99, 0)) < pct) begin
      bus.ic_req  = 1'b1;
      bus.ic_addr = $urandom;
    end
    if (!bus.dc_req && int'($urandom_range(99, 0)) < pct) begin
      bus.dc_req   = 1'b1;
      bus.dc_we    = 1'($urandom_range(1, 0));
      bus.dc_addr  = $urandom;
      bus.dc_wdata = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic waitDone(int icT, int dcT);
    int n = 0;
    while ((icDone < icT || dcDone < dcT) && n < 200) begin
      tick();
      n++;
    end
    chk("wait_timeout", LB'(n >= 200), '0);
  endtask

  task automatic drain();
    int n = 0;
    while ((bus.ic_req || bus.dc_req || expQ.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    chk("drain_timeout", LB'(n >= 300), '0);
  endtask

  task automatic pulseReset();
    @(posedge clock);
    #2 reset = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b0;
  endtask

  task automatic chkAllZero(string tag);
    chk({tag, "_ic_ready"},  LB'(bus.ic_ready), '0);
    chk({tag, "_dc_ready"},  LB'(bus.dc_ready), '0);
    chk({tag, "_ic_data"},   bus.ic_data, '0);
    chk({tag, "_dc_rdata"},  bus.dc_rdata, '0);
    chk({tag, "_mem_req"},   LB'(bus.mem_req), '0);
    chk({tag, "_mem_we"},    LB'(bus.mem_we), '0);
    chk({tag, "_mem_addr"},  LB'(bus.mem_addr), '0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, '0);
    chk({tag, "_busy"},      LB'(bus.busy), '0);
  endtask

  initial begin
    bus.ic_req = 1'b0;  bus.ic_addr = '0;
    bus.dc_req = 1'b0;  bus.dc_we = 1'b0;  bus.dc_addr = '0;  bus.dc_wdata = '0;
    bus1.ic_req = 1'b0; bus1.ic_addr = '0;
    bus1.dc_req = 1'b0; bus1.dc_we = 1'b0; bus1.dc_addr = '0; bus1.dc_wdata = '0;

    #1 chkAllZero("reset");
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;

    // Single ICache fill.
    @(negedge clock);
    bus.ic_req  = 1'b1;
    bus.ic_addr = 32'h10;
    waitDone(icDone + 1, dcDone);
    tick();
    tick();

    // Simultaneous requests after reset: DCache first, then ICache.
    pulseReset();
    @(negedge clock);
    bus.ic_req  = 1'b1; bus.ic_addr = 32'h20;
    bus.dc_req  = 1'b1; bus.dc_addr = 32'h40; bus.dc_we = 1'b0;
    waitDone(icDone + 1, dcDone + 1);

    // Both held continuously: grants alternate.
    pct = 100;
    waitDone(icDone + 4, dcDone + 4);
    pct = 0;
    drain();

    // DCache writeback.
    @(negedge clock);
    bus.dc_req   = 1'b1;
    bus.dc_we    = 1'b1;
    bus.dc_addr  = 32'h80;
    bus.dc_wdata = {4{32'hAAAA_AAAA}};
    waitDone(icDone, dcDone + 1);
    tick();

    // Reset in the third access cycle, request held across it.
    @(negedge clock);
    bus.ic_req  = 1'b1;
    bus.ic_addr = 32'h30;
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    #1 chkAllZero("abort");
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    waitDone(icDone + 1, dcDone);
    tick();

    // Random traffic.
    pct = 30;
    repeat (800) tick();
    pct = 0;
    drain();

    // One-cycle latency instance: single DCache read at 0x4.
    @(negedge clock);
    chk("lat1_busy_pre", LB'(bus1.busy), '0);
    bus1.dc_req  = 1'b1;
    bus1.dc_addr = 32'h4;
    @(negedge clock);
    chk("lat1_mem_req_c1", LB'(bus1.mem_req), LB'(1));
    chk("lat1_busy_c1", LB'(bus1.busy), LB'(1));
    chk("lat1_dc_ready_c1", LB'(bus1.dc_ready), '0);
    @(negedge clock);
    chk("lat1_mem_req_c2", LB'(bus1.mem_req), '0);
    chk("lat1_busy_c2", LB'(bus1.busy), LB'(1));
    chk("lat1_dc_ready_c2", LB'(bus1.dc_ready), LB'(1));
    chk("lat1_dc_rdata", bus1.dc_rdata, {4{32'h4}});
    chk("lat1_ic_ready_c2", LB'(bus1.ic_ready), '0);
    bus1.dc_req = 1'b0;
    @(negedge clock);
    chk("lat1_busy_c3", LB'(bus1.busy), '0);
    chk("lat1_dc_ready_c3", LB'(bus1.dc_ready), '0);

    chk("expq_empty", LB'(expQ.size()), '0);
    chk("wrq_empty", LB'(wrQ.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LATENCY, default 5: main-memory access cycles per transfer, legal range 1..15.
REQ-002 Parameter LINE_BITS, default 128: cache line width.
REQ-003 clock  input  1  sole clock; all state changes on posedge clock.
REQ-004 reset  input  1  asynchronous, active-high; asserting it immediately forces the reset state.
REQ-005 ic_req  input  1  ICache line-fill request, held until ic_ready.
REQ-006 ic_addr  input  32  ICache line address, held stable with ic_req.
REQ-007 ic_ready  output  1  one-cycle pulse: ic_data valid, request done.
REQ-008 ic_data  output  LINE_BITS  ICache fill data.
REQ-009 dc_req  input  1  DCache request (fill or writeback), held until dc_ready.
REQ-010 dc_we  input  1  1 = writeback, 0 = fill; stable with dc_req.
REQ-011 dc_addr  input  32  DCache line address.
REQ-012 dc_wdata  input  LINE_BITS  writeback line.
REQ-013 dc_ready  output  1  one-cycle completion pulse.
REQ-014 dc_rdata  output  LINE_BITS  DCache fill data.
REQ-015 mem_req  output  1  access in progress to backing memory.
REQ-016 mem_we  output  1  backing-memory write strobe.
REQ-017 mem_addr  output  32  backing-memory line address.
REQ-018 mem_wdata  output  LINE_BITS  backing-memory write data.
REQ-019 mem_rdata  input  LINE_BITS  combinational read data for mem_addr.
REQ-020 busy  output  1  high whenever state is not IDLE; feeds the top-level stall logic.

Function
REQ-021 FSM states: IDLE, ACCESS, RESPOND. At most one transfer in flight.
REQ-022 IDLE: if no request, remain. If exactly one of ic_req/dc_req is high, grant it. If both are high, grant the requester not granted last (last_grant).
- Action on a grant: latch owner, addr, we, wdata; update last_grant; load counter with LATENCY-1; go to ACCESS.
REQ-023 ACCESS: mem_req=1; mem_addr and mem_wdata come from the latched values.
- Counter decrements each cycle.
- When counter==0: capture mem_rdata if it is a read; assert mem_we for that single cycle if it is a write; go to RESPOND.
REQ-024 ACCESS therefore lasts exactly LATENCY cycles.
- mem_we is high in exactly one cycle per write and never during a read.
REQ-025 RESPOND: the owner's ready is high for exactly this one cycle; then go to IDLE unconditionally.
REQ-026 Latency: a request sampled at edge E0 in IDLE sees its ready high during the cycle after edge E0+LATENCY. Back-to-back transfers start no sooner than one IDLE cycle after RESPOND.
REQ-027 Requests are ignored outside IDLE. A req still high during RESPOND is not a new request; it is re-evaluated in IDLE.
REQ-028 ic_data/dc_rdata update only on their owner's read capture and hold otherwise.
- dc_rdata is unchanged by writebacks.
- The non-owner's data and ready never change.
REQ-029 Idle outputs: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-030 Deassertion of the owner's req mid-ACCESS does not abort the transfer; it completes and pulses ready.
REQ-031 LATENCY=1: ACCESS lasts one cycle; the counter loads 0.

Reset
REQ-032 While reset is high, the block is held in its reset state:
- state=IDLE, counter=0, last_grant=ICache (DCache wins the first tie);
- all outputs 0, including ic_data and dc_rdata.
REQ-033 Reset mid-ACCESS or mid-RESPOND aborts the transfer: no ready pulse, no mem_we.
- A request held across reset release is re-arbitrated from IDLE with full LATENCY.

Verification (LATENCY=5, mem model returns addr replicated into each 32-bit word)
REQ-034 Reset, then ic_req with ic_addr=0x10 at edge 0 -> mem_req high in cycles 1-5 with mem_addr=0x10; ic_ready high in cycle 6 with ic_data={4{0x10}}; dc_ready stays 0.
REQ-035 After reset, ic_req and dc_req rise together with ic_addr=0x20, dc_addr=0x40 -> DCache served first (dc_ready in cycle 6), ICache served next (ic_ready in cycle 13).
- Both held continuously -> grants strictly alternate.
REQ-036 dc_req=1, dc_we=1, dc_addr=0x80, dc_wdata=0xAAAA... -> mem_we high only in cycle 5 with mem_addr=0x80 and that wdata; dc_ready in cycle 6; dc_rdata unchanged.
REQ-037 Reset asserted in cycle 3 of ACCESS with ic_req held -> all outputs 0 asynchronously; no ic_ready.
- After release, ic_ready arrives LATENCY+1 cycles after the first IDLE sample.
REQ-038 LATENCY=1, single dc read at 0x4 -> mem_req for one cycle, dc_ready in cycle 2; busy high in exactly cycles 1-2.
